// File: rtl/sdram_responder.sv
`default_nettype none
// ============================================================================
// Module   : sdram_responder
// Brief    : Byte-wide SDRAM responder with programmable latency, acks and
//            access counters, used behind cache_top for line fills/write-backs.
// Revision : 1.0 - initial release
// ============================================================================
module sdram_responder #(
   parameter int ADDR_WIDTH     = 16,
   parameter int DATA_WIDTH     = 8,
   parameter int MEM_ADDR_WIDTH = 16,
   parameter int LATENCY        = 2,
   parameter int CNT_WIDTH      = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH-1:0] Address_sdram,
   input  logic                  wr_rd_sdram,
   input  logic                  mstrb_sdram,
   input  logic [DATA_WIDTH-1:0] DIn_sdram,
   output logic [DATA_WIDTH-1:0] DOut_sdram,
   output logic                  ack_sdram,
   output logic                  busy,
   output logic                  overrun,
   output logic [CNT_WIDTH-1:0]  rd_count,
   output logic [CNT_WIDTH-1:0]  wr_count
);

   localparam int         c_DEPTH    = 2 ** MEM_ADDR_WIDTH;
   localparam logic [3:0] c_CNT_INIT = 4'((LATENCY > 0) ? (LATENCY - 1) : 0);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_ACK  = 2'd2
   } state_t;

   state_t                    r_state;
   state_t                    w_next;
   logic [3:0]                r_cnt;
   logic [3:0]                w_cnt_next;
   logic                      r_mstrb_q;
   logic                      w_edge;
   logic                      w_accept;
   logic                      w_enter_ack;

   logic [MEM_ADDR_WIDTH-1:0] r_addr_q;
   logic                      r_wr_q;
   logic [DATA_WIDTH-1:0]     r_din_q;
   logic [MEM_ADDR_WIDTH-1:0] w_acc_addr;
   logic                      w_acc_wr;
   logic [DATA_WIDTH-1:0]     w_acc_din;
   logic [DATA_WIDTH-1:0]     w_pat;
   logic [DATA_WIDTH-1:0]     w_rd_data;

   logic [DATA_WIDTH-1:0]     r_dout;
   logic                      r_overrun;
   logic [CNT_WIDTH-1:0]      r_rd_count;
   logic [CNT_WIDTH-1:0]      r_wr_count;

   // Storage holds data XOR the low address byte, so an all-zero power-up
   // array reads back as mem[a] = a[7:0] without any initialisation logic.
   logic [DATA_WIDTH-1:0]     r_mem [c_DEPTH];

   assign w_edge = mstrb_sdram & ~r_mstrb_q;

   always_comb begin
      w_next     = r_state;
      w_cnt_next = r_cnt;
      w_accept   = 1'b0;
      case (r_state)
         S_IDLE, S_ACK: begin
            w_next = S_IDLE;
            if (w_edge) begin
               w_accept = 1'b1;
               if (LATENCY == 0) begin
                  w_next = S_ACK;
               end else begin
                  w_next     = S_WAIT;
                  w_cnt_next = c_CNT_INIT;
               end
            end
         end
         S_WAIT: begin
            if (r_cnt == 4'd0) begin
               w_next = S_ACK;
            end else begin
               w_cnt_next = r_cnt - 4'd1;
            end
         end
         default: w_next = S_IDLE;
      endcase
   end

   assign w_enter_ack = (w_next == S_ACK);

   // With zero latency the access completes on the capture edge itself,
   // so the live inputs stand in for the not-yet-captured copies.
   assign w_acc_addr = w_accept ? Address_sdram[MEM_ADDR_WIDTH-1:0] : r_addr_q;
   assign w_acc_wr   = w_accept ? wr_rd_sdram : r_wr_q;
   assign w_acc_din  = w_accept ? DIn_sdram : r_din_q;
   assign w_pat      = DATA_WIDTH'(w_acc_addr);
   assign w_rd_data  = r_mem[w_acc_addr] ^ w_pat;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= S_IDLE;
         r_cnt      <= 4'd0;
         r_mstrb_q  <= 1'b0;
         r_addr_q   <= '0;
         r_wr_q     <= 1'b0;
         r_din_q    <= '0;
         r_dout     <= '0;
         r_overrun  <= 1'b0;
         r_rd_count <= '0;
         r_wr_count <= '0;
      end else begin
         r_state   <= w_next;
         r_cnt     <= w_cnt_next;
         r_mstrb_q <= mstrb_sdram;
         if (w_accept) begin
            r_addr_q <= Address_sdram[MEM_ADDR_WIDTH-1:0];
            r_wr_q   <= wr_rd_sdram;
            r_din_q  <= DIn_sdram;
         end
         if ((r_state == S_WAIT) && w_edge) begin
            r_overrun <= 1'b1;
         end
         if (w_enter_ack) begin
            if (w_acc_wr) begin
               if (r_wr_count != '1) r_wr_count <= r_wr_count + 1'b1;
            end else begin
               r_dout <= w_rd_data;
               if (r_rd_count != '1) r_rd_count <= r_rd_count + 1'b1;
            end
         end
      end
   end

   // Gated by rst so a strobe seen during reset can never commit a write.
   always_ff @(posedge clk) begin
      if (rst && w_enter_ack && w_acc_wr) begin
         r_mem[w_acc_addr] <= w_acc_din ^ w_pat;
      end
   end

   assign DOut_sdram = r_dout;
   assign ack_sdram  = (r_state == S_ACK);
   assign busy       = (r_state == S_WAIT);
   assign overrun    = r_overrun;
   assign rd_count   = r_rd_count;
   assign wr_count   = r_wr_count;

endmodule
`default_nettype wire

// File: tb/tb_sdram_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_sdram_responder
// Brief    : Directed self-checking bench for sdram_responder (LATENCY 2 and 0).
// Revision : 1.0 - initial release
// ============================================================================
module tb_sdram_responder;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] addr, z_addr;
   logic        wr, z_wr;
   logic        mstrb, z_mstrb;
   logic [7:0]  din, z_din;
   logic [7:0]  dout, z_dout;
   logic        ack, z_ack;
   logic        busy, z_busy;
   logic        ovr, z_ovr;
   logic [15:0] rd_cnt, z_rd_cnt;
   logic [15:0] wr_cnt, z_wr_cnt;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   sdram_responder #(.LATENCY(2)) u_dut (
      .clk(clk), .rst(rst), .Address_sdram(addr), .wr_rd_sdram(wr),
      .mstrb_sdram(mstrb), .DIn_sdram(din), .DOut_sdram(dout),
      .ack_sdram(ack), .busy(busy), .overrun(ovr),
      .rd_count(rd_cnt), .wr_count(wr_cnt)
   );

   sdram_responder #(.LATENCY(0)) u_dut0 (
      .clk(clk), .rst(rst), .Address_sdram(z_addr), .wr_rd_sdram(z_wr),
      .mstrb_sdram(z_mstrb), .DIn_sdram(z_din), .DOut_sdram(z_dout),
      .ack_sdram(z_ack), .busy(z_busy), .overrun(z_ovr),
      .rd_count(z_rd_cnt), .wr_count(z_wr_cnt)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      tick();
   endtask

   // Issues one strobe pulse and returns cycles until ack (bounded).
   task automatic access(input logic [15:0] a, input logic w, input logic [7:0] d,
                         output int n);
      addr  = a;
      wr    = w;
      din   = d;
      mstrb = 1'b1;
      tick();
      mstrb = 1'b0;
      n = 1;
      while (!ack && n < 12) begin
         tick();
         n++;
      end
   endtask

   initial begin
      int n;
      int k;
      rst = 1'b0; mstrb = 1'b0; addr = '0; wr = 1'b0; din = '0;
      z_mstrb = 1'b0; z_addr = '0; z_wr = 1'b0; z_din = '0;
      tick();
      tick();
      check("rst_ack", ack, 0);
      check("rst_busy", busy, 0);
      check("rst_ovr", ovr, 0);
      check("rst_dout", dout, 0);
      check("rst_rd", rd_cnt, 0);
      check("rst_wr", wr_cnt, 0);
      rst = 1'b1;
      tick();

      // Read of untouched address: ack three clocks after the strobe edge.
      addr = 16'h1234; wr = 1'b0; mstrb = 1'b1;
      tick();
      check("t1_busy_e1", busy, 1);
      check("t1_ack_e1", ack, 0);
      mstrb = 1'b0;
      tick();
      check("t1_busy_e2", busy, 1);
      check("t1_ack_e2", ack, 0);
      tick();
      check("t1_ack_e3", ack, 1);
      check("t1_busy_e3", busy, 0);
      check("t1_dout", dout, 8'h34);
      check("t1_rd", rd_cnt, 1);
      tick();
      check("t1_ack_e4", ack, 0);

      // Write then read back the same address.
      access(16'h00E0, 1'b1, 8'hA5, n);
      check("t2_wr_lat", n, 3);
      check("t2_dout_hold", dout, 8'h34);
      check("t2_wr", wr_cnt, 1);
      access(16'h00E0, 1'b0, 8'h00, n);
      check("t2_rd_lat", n, 3);
      check("t2_dout", dout, 8'hA5);
      check("t2_rd", rd_cnt, 2);

      // 32-byte line fill, each strobe raised during the previous ACK.
      for (int i = 0; i < 32; i++) begin
         access(16'h2300 + 16'(i), 1'b0, 8'h00, n);
         check($sformatf("t3_lat[%0d]", i), n, 3);
         check($sformatf("t3_dout[%0d]", i), dout, i);
      end
      check("t3_ovr", ovr, 0);
      check("t3_rd", rd_cnt, 34);
      check("t3_wr", wr_cnt, 1);

      // Strobe edge while busy: ignored, overrun set and sticky.
      do_reset();
      check("t4_rd0", rd_cnt, 0);
      addr = 16'h0010; wr = 1'b0; mstrb = 1'b1;
      tick();
      check("t4_busy", busy, 1);
      mstrb = 1'b0;
      tick();
      check("t4_ovr_pre", ovr, 0);
      mstrb = 1'b1;
      tick();
      check("t4_ovr", ovr, 1);
      check("t4_ack", ack, 1);
      check("t4_dout", dout, 8'h10);
      mstrb = 1'b0;
      k = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         k += int'(ack);
      end
      check("t4_extra_acks", k, 0);
      check("t4_rd", rd_cnt, 1);
      check("t4_ovr_sticky", ovr, 1);
      do_reset();
      check("t4_ovr_clr", ovr, 0);

      // Reset during WAIT aborts a write; held strobe accepted after release.
      addr = 16'h0040; wr = 1'b1; din = 8'h5A; mstrb = 1'b1;
      tick();
      check("t5_busy", busy, 1);
      rst = 1'b0;
      #1;
      check("t5_busy_rst", busy, 0);
      tick();
      tick();
      check("t5_ack", ack, 0);
      check("t5_wr", wr_cnt, 0);
      wr = 1'b0;
      rst = 1'b1;
      tick();
      check("t5_accept", busy, 1);
      mstrb = 1'b0;
      tick();
      tick();
      check("t5_rd_ack", ack, 1);
      check("t5_dout", dout, 8'h40);
      check("t5_wr_after", wr_cnt, 0);
      check("t5_rd", rd_cnt, 1);

      // Zero-latency instance: ack on the clock right after the edge.
      tick();
      z_addr = 16'h0077; z_wr = 1'b0; z_mstrb = 1'b1;
      tick();
      check("t6_ack_e1", z_ack, 1);
      check("t6_busy", z_busy, 0);
      check("t6_dout", z_dout, 8'h77);
      z_mstrb = 1'b0;
      tick();
      check("t6_ack_e2", z_ack, 0);
      z_addr = 16'h0078; z_wr = 1'b1; z_din = 8'h99; z_mstrb = 1'b1;
      tick();
      check("t6_wr_ack", z_ack, 1);
      check("t6_wr_cnt", z_wr_cnt, 1);
      check("t6_dout_hold", z_dout, 8'h77);
      z_mstrb = 1'b0;
      tick();
      z_wr = 1'b0; z_mstrb = 1'b1;
      tick();
      check("t6_rd_ack", z_ack, 1);
      check("t6_rd_back", z_dout, 8'h99);
      check("t6_rd_cnt", z_rd_cnt, 2);
      z_mstrb = 1'b0;
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
